// File: rtl/cpuy_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpuy_irq_ctrl
// Brief    : Prioritised interrupt controller (EI > T0 > T1) with a
//            request/ack/EOI handshake towards the core and timer done acks.
// Revision : 1.0 - initial release
// ============================================================================
module cpuy_irq_ctrl #(
    parameter logic [11:0] EI_VECTOR   = 12'h010,
    parameter logic [11:0] T0_VECTOR   = 12'h020,
    parameter logic [11:0] T1_VECTOR   = 12'h030,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_int,
    input  logic        t0_done,
    input  logic        t1_done,
    input  logic [3:0]  cfg,
    input  logic        irq_ack,
    input  logic        eoi,
    output logic        irq_req,
    output logic [11:0] irq_vector,
    output logic [1:0]  irq_src,
    output logic        t0_done_ack,
    output logic        t1_done_ack,
    output logic [2:0]  pending,
    output logic        in_service
);

    localparam logic [1:0] c_src_none = 2'd0;
    localparam logic [1:0] c_src_ei   = 2'd1;
    localparam logic [1:0] c_src_t0   = 2'd2;
    localparam logic [1:0] c_src_t1   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQUEST    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ei_prev;
    logic                   r_t0_prev;
    logic                   r_t1_prev;

    logic [2:0]  r_pending;
    logic [2:0]  w_pending_nxt;
    logic [2:0]  w_set;
    logic [2:0]  w_clr;
    logic [2:0]  w_eligible;

    logic        r_irq_req;
    logic        w_irq_req_nxt;
    logic [1:0]  r_src;
    logic [1:0]  w_src_nxt;
    logic [11:0] r_vector;
    logic [11:0] w_vector_nxt;
    logic        r_in_service;
    logic        w_in_service_nxt;
    logic        r_t0_ack;
    logic        w_t0_ack_nxt;
    logic        r_t1_ack;
    logic        w_t1_ack_nxt;

    logic [1:0]  w_arb_src;
    logic [11:0] w_arb_vec;
    logic        w_src_en;
    logic        w_src_live;

    // ext_int is asynchronous; only the last synchroniser stage feeds logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_ei_prev <= 1'b0;
            r_t0_prev <= 1'b0;
            r_t1_prev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], ext_int};
            r_ei_prev <= r_sync[SYNC_STAGES-1];
            r_t0_prev <= t0_done;
            r_t1_prev <= t1_done;
        end
    end

    assign w_set = {t1_done & ~r_t1_prev,
                    t0_done & ~r_t0_prev,
                    r_sync[SYNC_STAGES-1] & ~r_ei_prev};

    // A set arriving in the same cycle as its clear keeps the bit high.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_set;

    assign w_eligible = r_pending & {cfg[0], cfg[1], cfg[2]} & {3{cfg[3]}};

    always_comb begin
        w_arb_src = c_src_none;
        w_arb_vec = 12'h000;
        if (w_eligible[0]) begin
            w_arb_src = c_src_ei;
            w_arb_vec = EI_VECTOR;
        end else if (w_eligible[1]) begin
            w_arb_src = c_src_t0;
            w_arb_vec = T0_VECTOR;
        end else if (w_eligible[2]) begin
            w_arb_src = c_src_t1;
            w_arb_vec = T1_VECTOR;
        end
    end

    always_comb begin
        w_src_en = 1'b0;
        case (r_src)
            c_src_ei: w_src_en = cfg[2];
            c_src_t0: w_src_en = cfg[1];
            c_src_t1: w_src_en = cfg[0];
            default:  w_src_en = 1'b0;
        endcase
    end

    assign w_src_live = cfg[3] & w_src_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pending    <= 3'b000;
            r_irq_req    <= 1'b0;
            r_src        <= c_src_none;
            r_vector     <= 12'h000;
            r_in_service <= 1'b0;
            r_t0_ack     <= 1'b0;
            r_t1_ack     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_irq_req    <= w_irq_req_nxt;
            r_src        <= w_src_nxt;
            r_vector     <= w_vector_nxt;
            r_in_service <= w_in_service_nxt;
            r_t0_ack     <= w_t0_ack_nxt;
            r_t1_ack     <= w_t1_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_irq_req_nxt    = r_irq_req;
        w_src_nxt        = r_src;
        w_vector_nxt     = r_vector;
        w_in_service_nxt = r_in_service;
        w_t0_ack_nxt     = 1'b0;
        w_t1_ack_nxt     = 1'b0;
        w_clr            = 3'b000;

        case (r_state)
            ST_IDLE: begin
                if ((|w_eligible) && !r_in_service) begin
                    w_irq_req_nxt = 1'b1;
                    w_src_nxt     = w_arb_src;
                    w_vector_nxt  = w_arb_vec;
                    w_state_nxt   = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                // Ack takes precedence over a coincident mask change or eoi.
                if (irq_ack) begin
                    case (r_src)
                        c_src_ei: w_clr = 3'b001;
                        c_src_t0: begin
                            w_clr        = 3'b010;
                            w_t0_ack_nxt = 1'b1;
                        end
                        c_src_t1: begin
                            w_clr        = 3'b100;
                            w_t1_ack_nxt = 1'b1;
                        end
                        default:  w_clr = 3'b000;
                    endcase
                    w_irq_req_nxt    = 1'b0;
                    w_in_service_nxt = 1'b1;
                    w_state_nxt      = ST_IN_SERVICE;
                end else if (!w_src_live) begin
                    w_irq_req_nxt = 1'b0;
                    w_src_nxt     = c_src_none;
                    w_vector_nxt  = 12'h000;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_IN_SERVICE: begin
                if (eoi) begin
                    w_in_service_nxt = 1'b0;
                    w_src_nxt        = c_src_none;
                    w_vector_nxt     = 12'h000;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign irq_req     = r_irq_req;
    assign irq_vector  = r_vector;
    assign irq_src     = r_src;
    assign t0_done_ack = r_t0_ack;
    assign t1_done_ack = r_t1_ack;
    assign pending     = r_pending;
    assign in_service  = r_in_service;

endmodule
`default_nettype wire
